// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-side responder: loader states and MMIO map.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        LD_CNT_HI = 2'b00,
        LD_CNT_LO = 2'b01,
        LD_DATA   = 2'b10,
        RUN       = 2'b11
    } ld_state_t;

    localparam logic [1:0] MMIO_CNT  = 2'b00;
    localparam logic [1:0] MMIO_LED  = 2'b01;
    localparam logic [1:0] MMIO_STAT = 2'b10;

    localparam int MMIO_SEL_BIT = 31;

endpackage

// File: rtl/mips_mem_responder_byte_packer.sv
// Packs loader bytes big-endian into 32-bit words; word_valid marks the 4th byte's accept cycle.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane <= 2'd0;
            hold <= 24'd0;
        end else if (byte_en) begin
            lane <= lane + 2'd1;
            hold <= {hold[15:0], byte_in};
        end
    end

    // The 4th byte is taken straight from the input so the word is written on its own edge.
    assign word_valid = byte_en && (lane == 2'd3);
    assign word       = {hold, byte_in};

endmodule

// File: rtl/mips_mem_responder.sv
// Unified memory port for the multicycle MIPS core: word RAM, small MMIO window, byte-stream boot loader.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int AW    = 6,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        ld_error,
    output logic [7:0]  led
);

    localparam int unsigned DEPTH = 1 << AW;

    ld_state_t        state;
    logic [7:0]       cnt_hi;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_index;
    logic [CNT_W-1:0] hdr;
    logic [31:0]      cycle_cnt;
    logic [31:0]      mem [DEPTH];

    logic        accept;
    logic        byte_en;
    logic        word_valid;
    logic [31:0] packed_word;
    logic        ld_we;
    logic        core_we;
    logic        mmio_sel;
    logic        unused_adr;

    assign accept   = ld_valid && ld_ready;
    assign byte_en  = accept && (state == LD_DATA);
    assign hdr      = CNT_W'({cnt_hi, ld_data});
    assign mmio_sel = adr[MMIO_SEL_BIT];
    assign core_we  = memwrite && (state == RUN) && !reset;
    // Words beyond the RAM depth are still consumed from the stream, just not stored.
    assign ld_we    = word_valid && (32'(word_index) < DEPTH) && !reset;
    assign unused_adr = ^{adr[30:AW+2], adr[1:0]};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_en    (byte_en),
        .byte_in    (ld_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_CNT_HI;
            ld_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            ld_error   <= 1'b0;
            cnt_hi     <= 8'd0;
            count      <= '0;
            word_index <= '0;
        end else begin
            case (state)
                LD_CNT_HI: begin
                    if (accept) begin
                        cnt_hi <= ld_data;
                        state  <= LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    if (accept) begin
                        count <= hdr;
                        if (hdr == '0) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= LD_DATA;
                            if (32'(hdr) > DEPTH) ld_error <= 1'b1;
                        end
                    end
                end
                LD_DATA: begin
                    if (word_valid) begin
                        word_index <= word_index + CNT_W'(1);
                        if (word_index == count - CNT_W'(1)) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A core store to the counter overrides that cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            led       <= 8'd0;
        end else begin
            if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
            if (core_we && mmio_sel) begin
                case (adr[3:2])
                    MMIO_CNT: cycle_cnt <= writedata;
                    MMIO_LED: led       <= writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we)
            mem[word_index[AW-1:0]] <= packed_word;
        else if (core_we && !mmio_sel)
            mem[adr[AW+1:2]] <= writedata;
    end

    always_comb begin
        readdata = 32'd0;
        if (!mmio_sel) begin
            readdata = mem[adr[AW+1:2]];
        end else begin
            case (adr[3:2])
                MMIO_CNT:  readdata = cycle_cnt;
                MMIO_LED:  readdata = {24'd0, led};
                MMIO_STAT: readdata = {30'd0, ld_error, state == RUN};
                default:   readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: loader sequences, MMIO and RAM reads checked through a scoreboard queue.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_reset;
    logic        ld_error;
    logic [7:0]  led;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    mips_mem_responder #(.AW(6), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .ld_error  (ld_error),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read data is queued with the request and retired when readdata settles.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        adr = a;
        #1;
        chk(tag, readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr = a; writedata = d; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic do_reset();
        ld_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        ld_valid = 1'b1; ld_data = b;
        @(negedge clk);
        ld_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; adr = 0; writedata = 0; memwrite = 0; ld_valid = 0; ld_data = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_ld_ready",  {31'd0, ld_ready},  32'd1);
        chk("rst_ld_error",  {31'd0, ld_error},  32'd0);
        chk("rst_led",       {24'd0, led},       32'd0);
        rd("rst_status", 32'h8000_0008, 32'h0);
        rd("rst_counter", 32'h8000_0000, 32'h0);

        // Back-to-back load of two words
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'h2008_0005, 0);
        send_byte(8'hAC, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
        chk("pre_last_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("pre_last_ld_ready",  {31'd0, ld_ready},  32'd1);
        send_byte(8'h40, 0);
        chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("run_ld_ready",  {31'd0, ld_ready},  32'd0);
        rd("ram0", 32'h0000_0000, 32'h2008_0005);
        rd("ram1", 32'h0000_0004, 32'hAC08_0040);
        rd("ram0_alias", 32'h0000_0102, 32'h2008_0005);
        rd("ram1_lowbits", 32'h0000_0007, 32'hAC08_0040);
        rd("status_run", 32'h8000_0008, 32'h1);

        // Loader bytes in RUN must be ignored
        send_word(32'hFFFF_FFFF, 0);
        rd("run_ld_ignored", 32'h0000_0000, 32'h2008_0005);

        // MMIO and RAM stores in RUN
        wr(32'h8000_0004, 32'h0000_01A5);
        chk("led_reg", {24'd0, led}, 32'hA5);
        rd("led_read", 32'h8000_0004, 32'hA5);
        wr(32'h8000_0000, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        rd("counter_wrap", 32'h8000_0000, 32'h0);
        wr(32'h8000_0000, 32'h1234_5678);
        rd("counter_write_wins", 32'h8000_0000, 32'h1234_5678);
        wr(32'h8000_000C, 32'hFFFF_FFFF);
        rd("mmio_11", 32'h8000_000C, 32'h0);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_store", 32'h0000_0010, 32'hDEAD_BEEF);

        // Zero-count header: straight to RUN, RAM retained across reset
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("zero_hdr_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        rd("zero_hdr_status", 32'h8000_0008, 32'h1);
        rd("zero_hdr_ram0", 32'h0000_0000, 32'h2008_0005);
        rd("led_cleared", 32'h8000_0004, 32'h0);

        // Clear the image, then reload it with gapped ld_valid
        wr(32'h0000_0000, 32'h0);
        wr(32'h0000_0004, 32'h0);
        do_reset();
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_word(32'h2008_0005, 1);
        send_word(32'hAC08_0040, 1);
        rd("gap_ram0", 32'h0000_0000, 32'h2008_0005);
        rd("gap_ram1", 32'h0000_0004, 32'hAC08_0040);
        rd("gap_status", 32'h8000_0008, 32'h1);

        // Overflow: 65 words into a 64-word RAM
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h41, 0);
        chk("ovf_ld_error", {31'd0, ld_error}, 32'd1);
        for (int k = 0; k < 65; k++) send_word(32'hA000_0000 | k, 0);
        chk("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        rd("ovf_ram0", 32'h0000_0000, 32'hA000_0000);
        rd("ovf_ram63", 32'h0000_00FC, 32'hA000_003F);
        rd("ovf_status", 32'h8000_0008, 32'h3);

        // Reset mid-load with memwrite held during the load
        do_reset();
        adr = 32'h0000_0008; writedata = 32'h0000_0BAD; memwrite = 1'b1;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        memwrite = 1'b0;
        do_reset();
        memwrite = 1'b1;
        chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("mid_ld_ready",  {31'd0, ld_ready},  32'd1);
        chk("mid_ld_error",  {31'd0, ld_error},  32'd0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hCAFE_BABE, 0);
        memwrite = 1'b0;
        rd("mid_ram0", 32'h0000_0000, 32'hCAFE_BABE);
        rd("mid_ram1", 32'h0000_0004, 32'hA000_0001);
        rd("mid_ram2", 32'h0000_0008, 32'hA000_0002);
        rd("mid_status", 32'h8000_0008, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
